sata_link_rx_framer: RTL and testbench

- Upstream neighbour of the Link-layer RX data path: takes the aligned 32-bit dword stream from the PHY, decodes SATA primitives, and extracts frame payload between SOF and EOF.
- Emits the scrambled payload plus CRC as rx_dat/rx_val/rx_eop, with eop on the final (CRC) dword.
- Reports the effective line primitive, honouring CONT and ignoring ALIGN, to the Link FSM.
- No backpressure: the downstream descrambler and CRC checker are always ready.

---
 rtl/sata_link_rx_framer.sv | 206 ++++++++++++++++++++
 tb/tb_sata_link_rx_framer.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/sata_link_rx_framer.sv
// SATA link RX framer: decodes primitives (with CONT/ALIGN handling) and extracts
// frame payload+CRC between SOF and EOF, releasing each dword one event late.
module sata_link_rx_framer #(
   parameter int unsigned MAXDWORDS = 2049
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] phy_dat,
   input  logic        phy_isk,
   input  logic        phy_val,
   output logic [31:0] rx_dat,
   output logic        rx_val,
   output logic        rx_eop,
   output logic [3:0]  line_prim,
   output logic        line_prim_val,
   output logic        in_frame,
   output logic        stat_abort,
   output logic        stat_short
);

   localparam int unsigned CW = $clog2(MAXDWORDS + 1);

   localparam logic [3:0] PrimData  = 4'd0;
   localparam logic [3:0] PrimSof   = 4'd1;
   localparam logic [3:0] PrimEof   = 4'd2;
   localparam logic [3:0] PrimHold  = 4'd3;
   localparam logic [3:0] PrimHolda = 4'd4;
   localparam logic [3:0] PrimSync  = 4'd5;
   localparam logic [3:0] PrimXrdy  = 4'd6;
   localparam logic [3:0] PrimRrdy  = 4'd7;
   localparam logic [3:0] PrimRip   = 4'd8;
   localparam logic [3:0] PrimRok   = 4'd9;
   localparam logic [3:0] PrimRerr  = 4'd10;
   localparam logic [3:0] PrimWtrm  = 4'd11;
   localparam logic [3:0] PrimDmat  = 4'd12;
   localparam logic [3:0] PrimUnk   = 4'd15;

   typedef enum logic [0:0] {StIdle, StFrame} state_e;

   state_e         state_q, state_d;
   logic           cont_q, cont_d;
   logic [3:0]     last_prim_q, last_prim_d;
   logic [31:0]    buf_dat_q, buf_dat_d;
   logic           buf_full_q, buf_full_d;
   logic [CW-1:0]  cnt_q, cnt_d;
   logic [31:0]    rx_dat_q, rx_dat_d;
   logic           rx_val_q, rx_val_d;
   logic           rx_eop_q, rx_eop_d;
   logic [3:0]     line_prim_q, line_prim_d;
   logic           line_prim_val_q, line_prim_val_d;
   logic           stat_abort_q, stat_abort_d;
   logic           stat_short_q, stat_short_d;

   logic [3:0]     prim_code;
   logic           is_align;
   logic           is_cont;

   always_comb begin
      prim_code = PrimUnk;
      is_align  = 1'b0;
      is_cont   = 1'b0;
      case (phy_dat)
         32'h3737B57C: prim_code = PrimSof;
         32'hD5D5B57C: prim_code = PrimEof;
         32'hD5D5AA7C: prim_code = PrimHold;
         32'h9595AA7C: prim_code = PrimHolda;
         32'h9999AA7C: is_cont   = 1'b1;
         32'h7B4A4ABC: is_align  = 1'b1;
         32'hB5B5957C: prim_code = PrimSync;
         32'h5757B57C: prim_code = PrimXrdy;
         32'h4A4A957C: prim_code = PrimRrdy;
         32'h5555B57C: prim_code = PrimRip;
         32'h3535B57C: prim_code = PrimRok;
         32'h5656B57C: prim_code = PrimRerr;
         32'h5858B57C: prim_code = PrimWtrm;
         32'h3636B57C: prim_code = PrimDmat;
         default:      prim_code = PrimUnk;
      endcase
   end

   always_comb begin
      state_d         = state_q;
      cont_d          = cont_q;
      last_prim_d     = last_prim_q;
      buf_dat_d       = buf_dat_q;
      buf_full_d      = buf_full_q;
      cnt_d           = cnt_q;
      rx_dat_d        = rx_dat_q;
      rx_val_d        = 1'b0;
      rx_eop_d        = 1'b0;
      line_prim_d     = line_prim_q;
      line_prim_val_d = 1'b0;
      stat_abort_d    = 1'b0;
      stat_short_d    = 1'b0;

      if (phy_val && phy_isk) begin
         if (is_cont) begin
            cont_d          = 1'b1;
            line_prim_d     = last_prim_q;
            line_prim_val_d = 1'b1;
         end else if (!is_align) begin
            cont_d          = 1'b0;
            last_prim_d     = prim_code;
            line_prim_d     = prim_code;
            line_prim_val_d = 1'b1;
            if (state_q == StIdle) begin
               if (prim_code == PrimSof) begin
                  state_d    = StFrame;
                  cnt_d      = '0;
                  buf_full_d = 1'b0;
               end
            end else begin
               if (prim_code == PrimEof) begin
                  if (buf_full_q) begin
                     rx_val_d = 1'b1;
                     rx_dat_d = buf_dat_q;
                     rx_eop_d = 1'b1;
                  end else begin
                     stat_short_d = 1'b1;
                  end
                  buf_full_d = 1'b0;
                  state_d    = StIdle;
               end else if (prim_code == PrimSync || prim_code == PrimSof) begin
                  // A nested SOF aborts the current frame and opens a fresh one.
                  if (buf_full_q) begin
                     rx_val_d = 1'b1;
                     rx_dat_d = buf_dat_q;
                     rx_eop_d = 1'b1;
                  end
                  stat_abort_d = 1'b1;
                  buf_full_d   = 1'b0;
                  cnt_d        = '0;
                  state_d      = (prim_code == PrimSof) ? StFrame : StIdle;
               end
            end
         end
      end else if (phy_val) begin
         line_prim_val_d = 1'b1;
         if (cont_q) begin
            line_prim_d = last_prim_q;
         end else begin
            line_prim_d = PrimData;
            if (state_q == StFrame) begin
               if (cnt_q == CW'(MAXDWORDS)) begin
                  rx_val_d     = 1'b1;
                  rx_dat_d     = buf_dat_q;
                  rx_eop_d     = 1'b1;
                  stat_abort_d = 1'b1;
                  buf_full_d   = 1'b0;
                  state_d      = StIdle;
               end else begin
                  if (buf_full_q) begin
                     rx_val_d = 1'b1;
                     rx_dat_d = buf_dat_q;
                  end
                  buf_dat_d  = phy_dat;
                  buf_full_d = 1'b1;
                  cnt_d      = cnt_q + CW'(1);
               end
            end
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q         <= StIdle;
         cont_q          <= 1'b0;
         last_prim_q     <= PrimSync;
         buf_dat_q       <= '0;
         buf_full_q      <= 1'b0;
         cnt_q           <= '0;
         rx_dat_q        <= '0;
         rx_val_q        <= 1'b0;
         rx_eop_q        <= 1'b0;
         line_prim_q     <= PrimSync;
         line_prim_val_q <= 1'b0;
         stat_abort_q    <= 1'b0;
         stat_short_q    <= 1'b0;
      end else begin
         state_q         <= state_d;
         cont_q          <= cont_d;
         last_prim_q     <= last_prim_d;
         buf_dat_q       <= buf_dat_d;
         buf_full_q      <= buf_full_d;
         cnt_q           <= cnt_d;
         rx_dat_q        <= rx_dat_d;
         rx_val_q        <= rx_val_d;
         rx_eop_q        <= rx_eop_d;
         line_prim_q     <= line_prim_d;
         line_prim_val_q <= line_prim_val_d;
         stat_abort_q    <= stat_abort_d;
         stat_short_q    <= stat_short_d;
      end
   end

   assign rx_dat        = rx_dat_q;
   assign rx_val        = rx_val_q;
   assign rx_eop        = rx_eop_q;
   assign line_prim     = line_prim_q;
   assign line_prim_val = line_prim_val_q;
   assign in_frame      = (state_q == StFrame);
   assign stat_abort    = stat_abort_q;
   assign stat_short    = stat_short_q;

endmodule

// File: tb/tb_sata_link_rx_framer.sv
// Directed bench for sata_link_rx_framer with a small MAXDWORDS to reach overlength.
module tb_sata_link_rx_framer;

   localparam logic [31:0] K_SOF   = 32'h3737B57C;
   localparam logic [31:0] K_EOF   = 32'hD5D5B57C;
   localparam logic [31:0] K_HOLD  = 32'hD5D5AA7C;
   localparam logic [31:0] K_HOLDA = 32'h9595AA7C;
   localparam logic [31:0] K_CONT  = 32'h9999AA7C;
   localparam logic [31:0] K_ALIGN = 32'h7B4A4ABC;
   localparam logic [31:0] K_SYNC  = 32'hB5B5957C;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic [31:0] phy_dat = '0;
   logic        phy_isk = 1'b0;
   logic        phy_val = 1'b0;
   logic [31:0] rx_dat;
   logic        rx_val;
   logic        rx_eop;
   logic [3:0]  line_prim;
   logic        line_prim_val;
   logic        in_frame;
   logic        stat_abort;
   logic        stat_short;

   int checks = 0;
   int failures = 0;

   sata_link_rx_framer #(.MAXDWORDS(4)) dut (
      .clk           (clk),
      .reset         (reset),
      .phy_dat       (phy_dat),
      .phy_isk       (phy_isk),
      .phy_val       (phy_val),
      .rx_dat        (rx_dat),
      .rx_val        (rx_val),
      .rx_eop        (rx_eop),
      .line_prim     (line_prim),
      .line_prim_val (line_prim_val),
      .in_frame      (in_frame),
      .stat_abort    (stat_abort),
      .stat_short    (stat_short)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Drive one input cycle, then sample #1 after the edge that consumed it.
   task automatic step(input logic [31:0] d, input logic k, input logic v);
      @(negedge clk);
      phy_dat = d;
      phy_isk = k;
      phy_val = v;
      @(posedge clk);
      #1;
   endtask

   task automatic prim(input logic [31:0] d);
      step(d, 1'b1, 1'b1);
   endtask

   task automatic data(input logic [31:0] d);
      step(d, 1'b0, 1'b1);
   endtask

   task automatic gap();
      step(32'h0, 1'b0, 1'b0);
   endtask

   task automatic chk_rx(input string tag, input logic v, input logic e, input logic [31:0] d);
      chk({tag, ".val"}, {31'b0, rx_val}, {31'b0, v});
      chk({tag, ".eop"}, {31'b0, rx_eop}, {31'b0, e});
      if (v) chk({tag, ".dat"}, rx_dat, d);
   endtask

   task automatic chk_lp(input string tag, input logic v, input logic [3:0] p);
      chk({tag, ".lpv"}, {31'b0, line_prim_val}, {31'b0, v});
      if (v) chk({tag, ".lp"}, {28'b0, line_prim}, {28'b0, p});
   endtask

   task automatic chk_reset_vals(input string tag);
      chk({tag, ".rx_dat"}, rx_dat, 32'h0);
      chk({tag, ".rx_val"}, {31'b0, rx_val}, 32'h0);
      chk({tag, ".rx_eop"}, {31'b0, rx_eop}, 32'h0);
      chk({tag, ".lp"}, {28'b0, line_prim}, 32'd5);
      chk({tag, ".lpv"}, {31'b0, line_prim_val}, 32'h0);
      chk({tag, ".in_frame"}, {31'b0, in_frame}, 32'h0);
      chk({tag, ".abort"}, {31'b0, stat_abort}, 32'h0);
      chk({tag, ".short"}, {31'b0, stat_short}, 32'h0);
   endtask

   initial begin
      // Reset state
      repeat (3) @(posedge clk);
      #1;
      chk_reset_vals("rst");
      @(negedge clk);
      reset = 1'b1;

      // Clean three-dword frame
      prim(K_SOF);  chk_lp("t1.sof", 1'b1, 4'd1); chk_rx("t1.sof", 1'b0, 1'b0, 32'h0);
      chk("t1.inf", {31'b0, in_frame}, 32'h1);
      data(32'h11111111); chk_lp("t1.d1", 1'b1, 4'd0); chk_rx("t1.d1", 1'b0, 1'b0, 32'h0);
      data(32'h22222222); chk_lp("t1.d2", 1'b1, 4'd0); chk_rx("t1.d2", 1'b1, 1'b0, 32'h11111111);
      data(32'h33333333); chk_rx("t1.d3", 1'b1, 1'b0, 32'h22222222);
      prim(K_EOF);  chk_lp("t1.eof", 1'b1, 4'd2); chk_rx("t1.eof", 1'b1, 1'b1, 32'h33333333);
      chk("t1.inf0", {31'b0, in_frame}, 32'h0);
      chk("t1.short", {31'b0, stat_short}, 32'h0);
      gap();        chk_lp("t1.gap", 1'b0, 4'd0); chk_rx("t1.gap", 1'b0, 1'b0, 32'h0);
      chk("t1.hold_dat", rx_dat, 32'h33333333);

      // ALIGNs and valid gaps are invisible
      prim(K_SOF);
      data(32'h11111111);
      prim(K_ALIGN); chk_lp("t2.al1", 1'b0, 4'd0); chk_rx("t2.al1", 1'b0, 1'b0, 32'h0);
      prim(K_ALIGN); chk_lp("t2.al2", 1'b0, 4'd0);
      chk("t2.inf", {31'b0, in_frame}, 32'h1);
      data(32'h22222222); chk_rx("t2.d2", 1'b1, 1'b0, 32'h11111111);
      gap();         chk_lp("t2.gap", 1'b0, 4'd0); chk_rx("t2.gap", 1'b0, 1'b0, 32'h0);
      data(32'h33333333); chk_rx("t2.d3", 1'b1, 1'b0, 32'h22222222);
      prim(K_EOF);   chk_rx("t2.eof", 1'b1, 1'b1, 32'h33333333);

      // CONT suppression of junk data
      prim(K_SOF);
      prim(K_HOLD);  chk_lp("t3.hold", 1'b1, 4'd3);
      prim(K_CONT);  chk_lp("t3.cont", 1'b1, 4'd3);
      for (int i = 0; i < 4; i++) begin
         data(32'hDEADBEEF);
         chk_lp("t3.junk", 1'b1, 4'd3);
         chk_rx("t3.junk", 1'b0, 1'b0, 32'h0);
         if (i == 1) begin
            prim(K_ALIGN); chk_lp("t3.al", 1'b0, 4'd0);
         end
      end
      prim(K_HOLDA); chk_lp("t3.holda", 1'b1, 4'd4);
      chk("t3.inf", {31'b0, in_frame}, 32'h1);
      data(32'h44444444); chk_lp("t3.d4", 1'b1, 4'd0); chk_rx("t3.d4", 1'b0, 1'b0, 32'h0);
      data(32'h55555555); chk_rx("t3.d5", 1'b1, 1'b0, 32'h44444444);
      prim(K_EOF);   chk_rx("t3.eof", 1'b1, 1'b1, 32'h55555555);

      // SYNC abort
      prim(K_SOF);
      data(32'h66666666);
      data(32'h77777777); chk_rx("t4.d2", 1'b1, 1'b0, 32'h66666666);
      prim(K_SYNC);  chk_rx("t4.sync", 1'b1, 1'b1, 32'h77777777);
      chk("t4.abort", {31'b0, stat_abort}, 32'h1);
      chk("t4.inf", {31'b0, in_frame}, 32'h0);
      chk_lp("t4.sync", 1'b1, 4'd5);
      gap();         chk("t4.abort0", {31'b0, stat_abort}, 32'h0);

      // Overlength with MAXDWORDS=4
      prim(K_SOF);
      data(32'hA0000001);
      data(32'hA0000002); chk_rx("t5.d2", 1'b1, 1'b0, 32'hA0000001);
      data(32'hA0000003); chk_rx("t5.d3", 1'b1, 1'b0, 32'hA0000002);
      data(32'hA0000004); chk_rx("t5.d4", 1'b1, 1'b0, 32'hA0000003);
      chk("t5.abort_pre", {31'b0, stat_abort}, 32'h0);
      data(32'hA0000005); chk_rx("t5.d5", 1'b1, 1'b1, 32'hA0000004);
      chk("t5.abort", {31'b0, stat_abort}, 32'h1);
      chk("t5.inf", {31'b0, in_frame}, 32'h0);
      data(32'hA0000006); chk_rx("t5.idle", 1'b0, 1'b0, 32'h0);
      chk("t5.abort0", {31'b0, stat_abort}, 32'h0);

      // Short frame
      prim(K_SOF);
      prim(K_EOF);   chk_rx("t5.short", 1'b0, 1'b0, 32'h0);
      chk("t5.short_p", {31'b0, stat_short}, 32'h1);
      chk("t5.short_ab", {31'b0, stat_abort}, 32'h0);
      gap();         chk("t5.short0", {31'b0, stat_short}, 32'h0);

      // Reset mid-frame
      prim(K_SOF);
      data(32'hBBBBBBBB);
      @(negedge clk);
      phy_val = 1'b0;
      reset = 1'b0;
      #1;
      chk_reset_vals("t6.rst");
      @(posedge clk);
      #1;
      chk("t6.rxv", {31'b0, rx_val}, 32'h0);
      @(negedge clk);
      reset = 1'b1;
      gap();         chk_rx("t6.gap", 1'b0, 1'b0, 32'h0);
      prim(K_SOF);   chk("t6.inf", {31'b0, in_frame}, 32'h1);
      data(32'hCCCCCCCC); chk_rx("t6.d1", 1'b0, 1'b0, 32'h0);
      prim(K_EOF);   chk_rx("t6.eof", 1'b1, 1'b1, 32'hCCCCCCCC);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
